// File: rtl/uart_tx_engine_cfg.sv
// rtl/uart_tx_engine_cfg.sv - configurable UART transmitter (5..MAX_DATA_BITS, N/E/O parity, 1/2 stop); optional line break via `UART_TX_BREAK_EN
module uart_tx_engine_cfg #(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     baud_tick,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_stop2,
  input  logic                     tx_in_valid,
  output logic                     tx_in_ready,
  input  logic [MAX_DATA_BITS-1:0] tx_in_data,
  output logic                     uart_tx,
  output logic                     tx_busy,
  output logic                     tx_done
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                     tx_break
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [3:0]    MAX_NB    = 4'(MAX_DATA_BITS);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

  state_t                   r_state;
  state_t                   w_state_next;
  logic [TW-1:0]            r_tick_cnt;
  logic [MAX_DATA_BITS-1:0] r_shift;
  logic [MAX_DATA_BITS-1:0] w_shift_next;
  logic [3:0]               r_bit_cnt;
  logic [3:0]               r_nbits;
  logic                     r_par_en;
  logic                     r_par_bit;
  logic                     r_stop2;
  logic                     r_stop_cnt;
  logic                     r_uart_tx;
  logic                     r_tx_done;
  logic                     w_tx_next;
  logic                     w_done_next;
  logic                     w_bit_end;
  logic                     w_ready;
  logic                     w_fire;
  logic                     w_brk_in;
  logic [3:0]               w_nbits;
  logic                     w_par_calc;
`ifdef UART_TX_BREAK_EN
  logic                     r_no_done;
  assign w_brk_in = tx_break;
`else
  assign w_brk_in = 1'b0;
`endif

  assign w_bit_end   = baud_tick && (r_tick_cnt == TICK_LAST);
  assign w_ready     = (r_state == S_IDLE) && !r_tx_done && !w_brk_in;
  assign w_fire      = tx_in_valid && w_ready;
  assign tx_in_ready = w_ready;
  assign uart_tx     = r_uart_tx;
  assign tx_busy     = (r_state != S_IDLE);
  assign tx_done     = r_tx_done;

  // Clamp the requested width and compute the parity of the bits actually sent
  always_comb begin
    w_nbits = cfg_data_bits;
    if (cfg_data_bits < 4'd5) w_nbits = 4'd5;
    else if (cfg_data_bits > MAX_NB) w_nbits = MAX_NB;
    w_par_calc = cfg_parity_odd;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < int'(w_nbits)) w_par_calc = w_par_calc ^ tx_in_data[i];
    end
  end

  // Next state, next shift register and the registered line level for the next cycle
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (tx_break) w_state_next = S_BREAK;
        else
`endif
        if (w_fire) begin
          w_state_next = S_START;
          w_shift_next = tx_in_data;
        end
      end
      S_START:  if (w_bit_end) w_state_next = S_DATA;
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == r_nbits - 4'd1) w_state_next = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
      S_STOP: begin
        if (w_bit_end && (!r_stop2 || r_stop_cnt)) begin
          w_state_next = S_IDLE;
`ifdef UART_TX_BREAK_EN
          w_done_next  = !r_no_done;
`else
          w_done_next  = 1'b1;
`endif
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK:  if (!tx_break) w_state_next = S_STOP;
`endif
      default:  w_state_next = S_IDLE;
    endcase
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = r_par_bit;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  w_tx_next = 1'b0;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Line/handshake outputs, tick counter and per-frame latched configuration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_uart_tx  <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_nbits    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
`ifdef UART_TX_BREAK_EN
      r_no_done  <= 1'b0;
`endif
    end else begin
      r_shift   <= w_shift_next;
      r_uart_tx <= w_tx_next;
      r_tx_done <= w_done_next;
`ifdef UART_TX_BREAK_EN
      if (r_state == S_IDLE || r_state == S_BREAK) r_tick_cnt <= '0;
`else
      if (r_state == S_IDLE) r_tick_cnt <= '0;
`endif
      else if (baud_tick) r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + TICK_ONE;
      if (w_fire) begin
        r_nbits    <= w_nbits;
        r_par_en   <= cfg_parity_en;
        r_par_bit  <= w_par_calc;
        r_stop2    <= cfg_stop2;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
`ifdef UART_TX_BREAK_EN
        r_no_done  <= 1'b0;
`endif
      end
      if (r_state == S_DATA && w_bit_end) r_bit_cnt <= r_bit_cnt + 4'd1;
      if (r_state == S_STOP && w_bit_end) r_stop_cnt <= 1'b1;
`ifdef UART_TX_BREAK_EN
      // Break release reuses the stop state as a single silent mark period
      if (r_state == S_BREAK) begin
        r_stop2    <= 1'b0;
        r_stop_cnt <= 1'b0;
        r_no_done  <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_engine_cfg.sv
// tb/tb_uart_tx_engine_cfg.sv - self-checking bench for uart_tx_engine_cfg (break tests under `UART_TX_BREAK_EN)
module tb_uart_tx_engine_cfg;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick = 1'b1;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en, cfg_parity_odd, cfg_stop2;
  logic       tx_in_valid;
  logic       tx_in_ready;
  logic [8:0] tx_in_data;
  logic       uart_tx, tx_busy, tx_done;
  logic       brk_sig = 1'b0;
  logic       slow = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_engine_cfg #(.OVERSAMPLE(OS), .MAX_DATA_BITS(9)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
    .tx_in_valid(tx_in_valid), .tx_in_ready(tx_in_ready), .tx_in_data(tx_in_data),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done)
`ifdef UART_TX_BREAK_EN
    , .tx_break(brk_sig)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) baud_tick = slow ? ($urandom_range(0, 2) == 0) : 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a list of line levels, each lasting OS baud ticks
  logic m_live = 1'b0;
  logic m_active, m_brk, m_done, m_tx, m_nodone;
  int   m_ticks, m_len;
  logic m_bits [0:15];

  always @(posedge clk) begin
    logic rdy;
    logic par;
    int   nb;
    rdy = m_live && !m_active && !m_brk && !m_done && !brk_sig;
    if (!rst_n) begin
      m_live = 1'b1; m_active = 1'b0; m_brk = 1'b0; m_done = 1'b0; m_tx = 1'b1; m_ticks = 0;
    end else if (m_live) begin
      m_done = 1'b0;
      if (m_brk) begin
        if (!brk_sig) begin
          m_brk = 1'b0; m_active = 1'b1; m_nodone = 1'b1; m_len = 1; m_bits[0] = 1'b1; m_ticks = 0;
        end
      end else if (m_active) begin
        if (baud_tick) m_ticks++;
        if (m_ticks == OS * m_len) begin
          m_active = 1'b0;
          m_done   = !m_nodone;
        end
      end else if (brk_sig) begin
        m_brk = 1'b1;
      end else if (rdy && tx_in_valid) begin
        nb = (cfg_data_bits < 5) ? 5 : (cfg_data_bits > 9) ? 9 : int'(cfg_data_bits);
        par = cfg_parity_odd;
        m_bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
          m_bits[1 + i] = tx_in_data[i];
          par = par ^ tx_in_data[i];
        end
        m_len = 1 + nb;
        if (cfg_parity_en) begin m_bits[m_len] = par; m_len++; end
        m_bits[m_len] = 1'b1; m_len++;
        if (cfg_stop2) begin m_bits[m_len] = 1'b1; m_len++; end
        m_active = 1'b1; m_nodone = 1'b0; m_ticks = 0;
      end
      m_tx = m_brk ? 1'b0 : (m_active ? m_bits[m_ticks / OS] : 1'b1);
    end
  end

  // Per-cycle comparison against the model, well clear of the active edge
  always @(negedge clk) begin
    #2;
    if (m_live) begin
      chk("uart_tx", int'(uart_tx), int'(m_tx));
      chk("tx_busy", int'(tx_busy), int'(m_active || m_brk));
      chk("tx_done", int'(tx_done), int'(m_done));
      chk("tx_in_ready", int'(tx_in_ready), int'(!m_active && !m_brk && !m_done && !brk_sig));
    end
  end

  // Offer one word, then sample the line mid-bit until tx_done or the cycle limit
  task automatic send(input logic [8:0] d, input logic keep, input logic [8:0] nxt,
                      input int toggle_k, input int rst_k, input int lim,
                      output logic [15:0] cap, output int done_k, output int wait_n);
    tx_in_data = d; tx_in_valid = 1'b1; wait_n = 0; cap = '0; done_k = -1;
    while (!tx_in_ready && wait_n < 500) begin
      @(negedge clk);
      wait_n++;
    end
    if (!tx_in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: ready never rose for data %0h", d);
      tx_in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (keep) tx_in_data = nxt; else tx_in_valid = 1'b0;
    for (int k = 0; k <= lim; k++) begin
      if (k > 0) @(negedge clk);
      if (k == toggle_k) begin
        cfg_data_bits = cfg_data_bits ^ 4'hF;
        cfg_parity_en = ~cfg_parity_en; cfg_parity_odd = ~cfg_parity_odd; cfg_stop2 = ~cfg_stop2;
      end
      if (k == rst_k) rst_n = 1'b0;
      if (rst_k >= 0 && k == rst_k + 1) begin
        rst_n = 1'b1;
        chk("rst_mid_uart_tx", int'(uart_tx), 1);
        chk("rst_mid_busy", int'(tx_busy), 0);
      end
      if (k % OS == OS / 2 && k / OS < 16) cap[k / OS] = uart_tx;
      if (tx_done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic pe, input logic po, input logic s2);
    cfg_data_bits = nb; cfg_parity_en = pe; cfg_parity_odd = po; cfg_stop2 = s2;
  endtask

  initial begin
    logic [15:0] cap;
    int done_k, wait_n;
    rst_n = 1'b0; tx_in_valid = 1'b0; tx_in_data = '0;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_uart_tx", int'(uart_tx), 1);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_done", int'(tx_done), 0);
    chk("reset_ready", int'(tx_in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0x55
    send(9'h055, 1'b0, 9'h0, -1, -1, 260, cap, done_k, wait_n);
    chk("8n1_55_bits", int'(cap[9:0]), 'h2AA);
    chk("8n1_55_done_clk", done_k, 160);

    // 7E2 0x41
    set_cfg(4'd7, 1'b1, 1'b0, 1'b1);
    send(9'h041, 1'b0, 9'h0, -1, -1, 260, cap, done_k, wait_n);
    chk("7e2_41_bits", int'(cap[10:0]), 'h682);
    chk("7e2_41_done_clk", done_k, 176);

    // 9O1 0x1A5 with configuration flipped mid-frame
    set_cfg(4'd9, 1'b1, 1'b1, 1'b0);
    send(9'h1A5, 1'b0, 9'h0, 50, -1, 260, cap, done_k, wait_n);
    chk("9o1_1a5_bits", int'(cap[11:0]), 'hB4A);
    chk("9o1_1a5_done_clk", done_k, 192);

    // valid held across two frames
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    send(9'h00F, 1'b1, 9'h0F0, -1, -1, 260, cap, done_k, wait_n);
    chk("b2b_first_bits", int'(cap[9:0]), 'h21E);
    chk("b2b_first_done_clk", done_k, 160);
    send(9'h0F0, 1'b0, 9'h0, -1, -1, 260, cap, done_k, wait_n);
    chk("b2b_ready_gap", wait_n, 1);
    chk("b2b_second_bits", int'(cap[9:0]), 'h3E0);
    chk("b2b_second_done_clk", done_k, 160);

    // width clamping
    set_cfg(4'd3, 1'b0, 1'b0, 1'b0);
    send(9'h0EB, 1'b0, 9'h0, -1, -1, 260, cap, done_k, wait_n);
    chk("clamp_low_bits", int'(cap[6:0]), 'h56);
    chk("clamp_low_done_clk", done_k, 112);
    set_cfg(4'd15, 1'b0, 1'b0, 1'b0);
    send(9'h155, 1'b0, 9'h0, -1, -1, 260, cap, done_k, wait_n);
    chk("clamp_high_bits", int'(cap[10:0]), 'h6AA);
    chk("clamp_high_done_clk", done_k, 176);

    // reset during data bit 3, then a clean frame
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    send(9'h0A5, 1'b0, 9'h0, -1, 70, 260, cap, done_k, wait_n);
    chk("rst_mid_no_done", done_k, -1);
    send(9'h0A5, 1'b0, 9'h0, -1, -1, 260, cap, done_k, wait_n);
    chk("post_rst_bits", int'(cap[9:0]), 'h34A);
    chk("post_rst_done_clk", done_k, 160);

    // sparse baud ticks, 8O1
    slow = 1'b1;
    set_cfg(4'd8, 1'b1, 1'b1, 1'b0);
    send(9'h03C, 1'b0, 9'h0, -1, -1, 3000, cap, done_k, wait_n);
    chk("slow_tick_completed", int'(done_k >= 176), 1);
    @(negedge clk);
    slow = 1'b0;
    repeat (3) @(negedge clk);

`ifdef UART_TX_BREAK_EN
    begin
      int zeros, ones;
      zeros = 0; ones = 0;
      brk_sig = 1'b1;
      repeat (100) begin
        @(negedge clk);
        if (uart_tx == 1'b0) zeros++;
      end
      brk_sig = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (tx_in_ready) break;
        if (uart_tx == 1'b1) ones++;
      end
      chk("break_low_clks", zeros, 100);
      chk("break_mark_clks", ones, 16);
      chk("break_ready_after", int'(tx_in_ready), 1);
    end
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
